// File: rtl/rsa_result_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_result_serializer_if
//  Purpose  : Chunk stream (dout / dout_valid / dout_ready) between the RSA
//             result serializer (master) and the output pin / SPI layer
//             (slave).
//  Revision : 1.0  - initial release
// ============================================================================
interface rsa_result_serializer_if #(
    parameter int DW = 2
);
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface
`default_nettype wire

// File: rtl/rsa_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_result_serializer
//  Purpose  : Snapshots the WIDTH-bit Montgomery result on start and streams
//             it out in DW-bit chunks over a valid/ready handshake, pulsing
//             done for one cycle after the final chunk.
//  Options  : RSA_SER_MSB_FIRST_EN - when defined the most significant chunk
//             is sent first; otherwise the least significant chunk leads.
//  Revision : 1.0  - initial release
// ============================================================================
module rsa_result_serializer #(
    parameter int WIDTH = 8,
    parameter int DW    = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               ena,
    input  wire logic               start,
    input  wire logic               abort,
    input  wire logic [WIDTH-1:0]   R_i,
    rsa_result_serializer_if.master dout_if,
    output logic                    busy,
    output logic                    done
);

    localparam int NCHUNK = WIDTH / DW;
    localparam int CW     = $clog2(NCHUNK + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [DW-1:0]    w_chunk;
    logic [WIDTH-1:0] w_shifted;
    logic             w_valid;

    // Output end of the shift register and its one-chunk-advanced image.
`ifdef RSA_SER_MSB_FIRST_EN
    assign w_chunk   = r_shreg[WIDTH-1 -: DW];
    assign w_shifted = {r_shreg[WIDTH-DW-1:0], {DW{1'b0}}};
`else
    assign w_chunk   = r_shreg[DW-1:0];
    assign w_shifted = {{DW{1'b0}}, r_shreg[WIDTH-1:DW]};
`endif

    // Outputs depend only on registered state plus ena/abort, never dout_ready.
    assign w_valid            = (r_state == c_SEND) && ena && !abort;
    assign dout_if.dout_valid = w_valid;
    assign dout_if.dout       = (r_state == c_SEND) ? w_chunk : {DW{1'b0}};
    assign busy               = (r_state == c_SEND) || (r_state == c_DONE);
    assign done               = (r_state == c_DONE) && ena;

    // State register; ena gating is folded into the next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_shreg <= {WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: capture, shift-per-transfer, abort and freeze on !ena.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        if (ena) begin
            case (r_state)
                c_IDLE: begin
                    // abort beats a simultaneous start
                    if (abort) begin
                        w_cnt_nxt = {CW{1'b0}};
                    end else if (start) begin
                        w_shreg_nxt = R_i;
                        w_cnt_nxt   = CW'(NCHUNK);
                        w_state_nxt = c_SEND;
                    end
                end
                c_SEND: begin
                    if (abort) begin
                        w_cnt_nxt   = {CW{1'b0}};
                        w_state_nxt = c_IDLE;
                    end else if (dout_if.dout_ready) begin
                        w_shreg_nxt = w_shifted;
                        w_cnt_nxt   = r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            w_state_nxt = c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    if (abort) begin
                        w_cnt_nxt = {CW{1'b0}};
                    end
                    w_state_nxt = c_IDLE;
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rsa_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rsa_result_serializer
//  Purpose  : Self-checking bench for rsa_result_serializer (WIDTH=8, DW=2):
//             directed scenarios followed by random traffic, all compared
//             against a queue-based transaction model.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_rsa_result_serializer;

    localparam int WIDTH  = 8;
    localparam int DW     = 2;
    localparam int NCHUNK = WIDTH / DW;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] R_i;
    logic             busy;
    logic             done;

    rsa_result_serializer_if #(.DW(DW)) dout_if ();

    rsa_result_serializer #(
        .WIDTH (WIDTH),
        .DW    (DW)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .start   (start),
        .abort   (abort),
        .R_i     (R_i),
        .dout_if (dout_if),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Model: chunks still owed to the consumer, and a pending done pulse.
    int unsigned m_q[$];
    bit          m_send;
    bit          m_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int obs[$];
    int done_cnt;
    int busy_cnt;
    int last_done_cyc;
    int start_cyc;
    int exp_b4[4];
    int exp_1e[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Split a result into the chunk order the consumer should see.
    function automatic void model_load(input logic [WIDTH-1:0] r);
        int unsigned c;
        m_q.delete();
        for (int k = 0; k < NCHUNK; k++) begin
            c = (int'(r) >> (DW * k)) & ((1 << DW) - 1);
`ifdef RSA_SER_MSB_FIRST_EN
            m_q.push_front(c);
`else
            m_q.push_back(c);
`endif
        end
    endfunction

    task automatic drv(input logic r, input logic e, input logic s, input logic a,
                       input logic rd, input logic [WIDTH-1:0] d);
        rst = r; ena = e; start = s; abort = a; dout_if.dout_ready = rd; R_i = d;
    endtask

    // One clock: compare outputs mid-cycle, advance the model, pass the edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        check("busy",       32'(busy),               32'(m_send || m_done));
        check("dout_valid", 32'(dout_if.dout_valid), 32'(m_send && ena && !abort));
        check("dout",       32'(dout_if.dout),       m_send ? m_q[0] : 32'd0);
        check("done",       32'(done),               32'(m_done && ena));
        if (dout_if.dout_valid && dout_if.dout_ready) obs.push_back(int'(dout_if.dout));
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (rst) begin
            m_q.delete(); m_send = 0; m_done = 0;
        end else if (ena) begin
            if (m_done) begin
                m_done = 0;
            end else if (m_send) begin
                if (abort) begin
                    m_q.delete(); m_send = 0;
                end else if (dout_if.dout_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_send = 0; m_done = 1;
                    end
                end
            end else if (start && !abort) begin
                model_load(R_i);
                m_send = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs.delete(); done_cnt = 0; busy_cnt = 0; last_done_cyc = -1;
    endtask

    task automatic check_seq(input string tag, input int exp[4]);
        check({tag, "_n"}, 32'(obs.size()), 32'd4);
        for (int i = 0; i < obs.size() && i < 4; i++) check(tag, 32'(obs[i]), 32'(exp[i]));
    endtask

    initial begin
`ifdef RSA_SER_MSB_FIRST_EN
        exp_b4 = '{2, 3, 1, 0};
        exp_1e = '{0, 1, 3, 2};
`else
        exp_b4 = '{0, 1, 3, 2};
        exp_1e = '{2, 3, 1, 0};
`endif
        m_send = 0; m_done = 0;
        drv(1, 1, 0, 0, 0, 8'h00);
        step(); step();
        drv(0, 1, 0, 0, 1, 8'h00);
        step();
        check("rst_busy", 32'(busy), 32'd0);

        // Basic stream.
        clear_obs();
        drv(0, 1, 1, 0, 1, 8'hB4); step(); start_cyc = cyc;
        drv(0, 1, 0, 0, 1, 8'hB4);
        repeat (7) step();
        check_seq("basic", exp_b4);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);
        check("basic_latency",  32'(last_done_cyc - start_cyc), 32'd5);
        check("basic_busy_cyc", 32'(busy_cnt), 32'd5);

        // Backpressure: ready pattern 1,0,0,1,0,1,1.
        clear_obs();
        drv(0, 1, 1, 0, 0, 8'hB4); step(); start_cyc = cyc;
        foreach (exp_b4[i]) ; // no-op keeps loop variable local elsewhere
        for (int i = 0; i < 7; i++) begin
            drv(0, 1, 0, 0, (7'b1101001 >> i) & 1'b1, 8'h00);
            step();
        end
        drv(0, 1, 0, 0, 0, 8'h00);
        repeat (3) step();
        check_seq("bp", exp_b4);
        check("bp_done_cnt", 32'(done_cnt), 32'd1);
        check("bp_latency",  32'(last_done_cyc - start_cyc), 32'd8);

        // Capture isolation: R_i changes and a mid-stream start are ignored.
        clear_obs();
        drv(0, 1, 1, 0, 1, 8'hB4); step();
        drv(0, 1, 0, 0, 1, 8'hFF); step();
        drv(0, 1, 1, 0, 1, 8'hFF); step();
        drv(0, 1, 0, 0, 1, 8'hFF);
        repeat (5) step();
        check_seq("iso", exp_b4);
        check("iso_done_cnt", 32'(done_cnt), 32'd1);

        // Abort after two transfers, then a fresh capture.
        clear_obs();
        drv(0, 1, 1, 0, 1, 8'hB4); step();
        drv(0, 1, 0, 0, 1, 8'hB4); step(); step();
        drv(0, 1, 0, 1, 1, 8'hB4); step();
        drv(0, 1, 0, 0, 1, 8'hB4); step(); step();
        check("abort_xfers",    32'(obs.size()), 32'd2);
        check("abort_no_done",  32'(done_cnt), 32'd0);
        clear_obs();
        drv(0, 1, 1, 0, 1, 8'h1E); step();
        drv(0, 1, 0, 0, 1, 8'h00);
        repeat (6) step();
        check_seq("after_abort", exp_1e);

        // Reset mid-stream.
        drv(0, 1, 1, 0, 1, 8'h5A); step();
        drv(0, 1, 0, 0, 1, 8'h5A); step();
        drv(1, 1, 0, 0, 1, 8'h5A); step();
        drv(0, 1, 0, 0, 1, 8'h5A); step();
        check("rst_mid_busy", 32'(busy), 32'd0);

        // ena gap of three cycles during SEND.
        clear_obs();
        drv(0, 1, 1, 0, 1, 8'hB4); step(); start_cyc = cyc;
        drv(0, 1, 0, 0, 1, 8'hB4); step();
        drv(0, 0, 0, 0, 1, 8'hB4); repeat (3) step();
        drv(0, 1, 0, 0, 1, 8'hB4); repeat (6) step();
        check_seq("ena_gap", exp_b4);
        check("ena_latency", 32'(last_done_cyc - start_cyc), 32'd8);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drv(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                $urandom_range(0, 1), WIDTH'($urandom));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
